// File: rtl/react_pkg.sv
// rtl/react_pkg.sv - shared types and constants for the react_lanes reactor
package react_pkg;

  typedef enum logic [1:0] {
    PASS   = 2'd0,
    INVERT = 2'd1,
    ACCUM  = 2'd2,
    EDGE   = 2'd3
  } mode_t;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam int STEP_W = 16;

endpackage

// File: rtl/react_lane.sv
// rtl/react_lane.sv - one lane: registered result and last sampled input
module react_lane
  import react_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_nxt;

  always_comb begin
    w_nxt = r_out;
    case (i_mode)
      PASS:    w_nxt = i_x;
      INVERT:  w_nxt = ~i_x;
      ACCUM:   w_nxt = r_out ^ i_x;
      EDGE:    w_nxt = i_x ^ r_prev;
      default: w_nxt = r_out;
    endcase
  end

  // prev tracks the input on every enabled step so EDGE is correct after any mode switch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out  <= '0;
      r_prev <= '0;
    end else if (i_en) begin
      r_out  <= w_nxt;
      r_prev <= i_x;
    end
  end

  assign o_q = r_out;

endmodule

// File: rtl/react_lanes.sv
// rtl/react_lanes.sv - multi-lane reactive transform with step budget and stop
module react_lanes
  import react_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 2,
  parameter int MAX_STEPS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES*WIDTH-1:0] __in0,
  input  logic [1:0]             __in1,
  input  logic                   __in2,
  output logic [LANES*WIDTH-1:0] __out0,
  output logic                   __out1,
  output logic [STEP_W-1:0]      __out2
);

  localparam bit              BOUNDED = (MAX_STEPS != 0);
  localparam logic [STEP_W-1:0] MAX_C = STEP_W'(MAX_STEPS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [STEP_W-1:0] r_cnt;
  logic [STEP_W-1:0] w_cnt_nxt;
  logic              w_step;
  mode_t             w_mode;

  assign w_mode = mode_t'(__in1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stop wins over a step: nothing updates and the count stays where it was
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_step      = 1'b0;
    case (r_state)
      RUN: begin
        if (__in2) begin
          w_state_nxt = DONE;
        end else begin
          w_step = 1'b1;
          if (r_cnt != {STEP_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
          if (BOUNDED && (w_cnt_nxt == MAX_C)) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    react_lane #(.WIDTH(WIDTH)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_step),
      .i_mode (w_mode),
      .i_x    (__in0[k*WIDTH +: WIDTH]),
      .o_q    (__out0[k*WIDTH +: WIDTH])
    );
  end

  assign __out1 = (r_state == DONE);
  assign __out2 = r_cnt;

endmodule

// File: doc/react_lanes.md
# react_lanes

Parametrised reactive transform block and successor to the single-bit inverting reactor. It applies a per-cycle, mode-selected transform to `LANES` independent `WIDTH`-bit lanes, with registered outputs. It adds a step counter and explicit termination: the reactor stops on an external stop request or after `MAX_STEPS` steps, then freezes its outputs. It sits at the edge of a ReWire-generated datapath and drives the next reactive stage.

## Interface
Parameters:
- `WIDTH`, 8, bits per lane (≥1)
- `LANES`, 2, number of independent lanes (≥1)
- `MAX_STEPS`, 0, step budget; 0 = unbounded; otherwise 1..65535

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `__in0`  in  LANES*WIDTH  lane data; lane k = bits [k*WIDTH +: WIDTH]
- `__in1`  in  2  mode: 0 PASS, 1 INVERT, 2 ACCUM, 3 EDGE
- `__in2`  in  1  stop request
- `__out0`  out  LANES*WIDTH  registered lane results
- `__out1`  out  1  done (reactor terminated)
- `__out2`  out  16  step count

## Operation
- States: RUN (the state after reset) and DONE. There is no exit from DONE except reset.
- Per-lane state: `out_q[k]` (drives `__out0`) and `prev_q[k]` (last sampled input).
- In RUN, on each rising edge with `__in2`=0, each lane updates as follows, with `x` = lane input:
  - PASS: `out_q` <= `x`
  - INVERT: `out_q` <= `~x`
  - ACCUM: `out_q` <= `out_q ^ x`
  - EDGE: `out_q` <= `x ^ prev_q`
- `prev_q` <= `x` on every RUN step, in all modes. The step count increments by 1.
- Stop: in RUN with `__in2`=1, the edge updates nothing (`out_q`, `prev_q` and count all hold) and the state moves to DONE.
- Budget: with `MAX_STEPS`≠0, a step that brings the count to `MAX_STEPS` completes normally, updating the outputs. The state then moves to DONE on the same edge.
- Stop has priority: if stop and the budget step coincide, the stop behaviour applies and the count stays at `MAX_STEPS`-1.
- With `MAX_STEPS`=0 the count saturates at 16'hFFFF and the reactor continues running.
- In DONE, all registers hold and inputs are ignored. `__out1`=1.
- Mode can change on any cycle. The new mode applies to the step sampled on that edge. ACCUM and EDGE use the current `out_q`/`prev_q` regardless of earlier modes.
- Lanes are fully independent. All lanes share the mode, stop and counter.

## Timing
- Reset values while `rst`=0 (asynchronous):
  - `__out0`=0, `__out1`=0, `__out2`=0
  - all `prev_q`=0
  - state RUN
- Latency: one cycle. The input sampled at edge n appears on `__out0` after edge n.
- `__out1` rises after the edge that enters DONE, and in the same cycle that the final `__out0`/`__out2` values appear.
- Reset asserted mid-run or in DONE clears everything immediately. The first step after release is sampled at the first rising edge with `rst`=1.
- There is no combinational path from inputs to outputs.

## Structure
- Package `react_pkg`:
  - `mode_t` enum (PASS, INVERT, ACCUM, EDGE; 2 bits)
  - `state_t` enum (RUN, DONE)
  - `STEP_W` = 16
- Sub-module `react_lane` (`WIDTH` parameter): holds `out_q` and `prev_q` and the mode mux, with an update-enable input. It is instantiated `LANES` times in a generate loop.
- The top level holds the FSM, the counter and the enable/stop logic.

## Test plan
- Reset, then INVERT, WIDTH=8, LANES=2, `__in0`=16'h0F00 → one cycle later `__out0`=16'hF0FF, `__out2`=1, `__out1`=0.
- ACCUM, inputs 8'h01, 8'h03, 8'h06 in successive cycles on lane 0 → `__out0` lane 0 sequence is 01, 02, 04.
- EDGE after reset, inputs 8'hAA, 8'hAA, 8'h55 → outputs AA, 00, FF. Switching from PASS to EDGE mid-stream must use the correct `prev_q`.
- MAX_STEPS=3, PASS, inputs 1, 2, 3, 4 → `__out0`=3, `__out2`=3, `__out1`=1 after the third edge; the input 4 is ignored and outputs stay frozen.
- `__in2`=1 on step 2 → `__out0` keeps the step-1 value, `__out2`=1, `__out1`=1. A coincident stop and budget edge with MAX_STEPS=2 → count stays at 1.
- Assert `rst` asynchronously in DONE, between clock edges → all outputs go to 0 immediately. The reactor runs again after release.
